stage_skid_reg: RTL and testbench

STAGE_SKID_REG -- requirements
Module: stage_skid_reg

---
 rtl/stage_skid_reg.sv | 135 +++++++++++++
 tb/tb_stage_skid_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_skid_reg.sv
// Two-entry skid register between pipeline stages.
// in_ready depends only on registered state and freeze, so out_ready has no path to it.
module stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic [DATA_W-1:0] src2,
  input  logic [DEST_W-1:0] Dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_EN_Out,
  output logic              MEM_R_EN_Out,
  output logic              MEM_W_EN_Out,
  output logic [DATA_W-1:0] ALU_Result_Out,
  output logic [DATA_W-1:0] src2_out,
  output logic [DEST_W-1:0] Dest_Out,
  input  logic              freeze,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              wb;
    logic              mr;
    logic              mw;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] src2;
  } pay_t;

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  pay_t             m_q, m_d;
  pay_t             s_q, s_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  pay_t in_pay;
  logic acc;
  logic pop;

  assign in_pay = '{
    wb:   WB_EN,
    mr:   MEM_R_EN,
    mw:   MEM_W_EN,
    dest: Dest,
    alu:  ALU_Result,
    src2: src2
  };

  assign in_ready  = (state_q != FULL) & ~freeze;
  assign out_valid = (state_q != EMPTY) & ~freeze;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            m_d     = in_pay;
          end
        end
        ONE: begin
          if (acc && pop) begin
            m_d = in_pay;
          end else if (acc) begin
            state_d = FULL;
            s_d     = in_pay;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      stall_q <= stall_d;
    end
  end

  assign count          = state_q;
  assign stall_cnt      = stall_q;
  assign WB_EN_Out      = m_q.wb & out_valid;
  assign MEM_R_EN_Out   = m_q.mr & out_valid;
  assign MEM_W_EN_Out   = m_q.mw & out_valid;
  assign Dest_Out       = m_q.dest;
  assign ALU_Result_Out = m_q.alu;
  assign src2_out       = m_q.src2;

endmodule

// File: tb/tb_stage_skid_reg.sv
// Directed bench for stage_skid_reg.
// A second instance with CNT_W=2 shares the stimulus for counter saturation.
module tb_stage_skid_reg;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          wb, mr, mw;
  logic [DW-1:0] alu, s2;
  logic [RW-1:0] dst;
  logic          out_valid;
  logic          out_ready;
  logic          wb_o, mr_o, mw_o;
  logic [DW-1:0] alu_o, s2_o;
  logic [RW-1:0] dst_o;
  logic          freeze, flush;
  logic [1:0]    count;
  logic [CW-1:0] stall;

  logic          b_in_ready, b_out_valid;
  logic          b_wb_o, b_mr_o, b_mw_o;
  logic [DW-1:0] b_alu_o, b_s2_o;
  logic [RW-1:0] b_dst_o;
  logic [1:0]    b_count;
  logic [1:0]    b_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stage_skid_reg #(.DATA_W(DW), .DEST_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB_EN(wb), .MEM_R_EN(mr), .MEM_W_EN(mw),
    .ALU_Result(alu), .src2(s2), .Dest(dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_EN_Out(wb_o), .MEM_R_EN_Out(mr_o), .MEM_W_EN_Out(mw_o),
    .ALU_Result_Out(alu_o), .src2_out(s2_o), .Dest_Out(dst_o),
    .freeze(freeze), .flush(flush),
    .count(count), .stall_cnt(stall)
  );

  stage_skid_reg #(.DATA_W(DW), .DEST_W(RW), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .WB_EN(wb), .MEM_R_EN(mr), .MEM_W_EN(mw),
    .ALU_Result(alu), .src2(s2), .Dest(dst),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .WB_EN_Out(b_wb_o), .MEM_R_EN_Out(b_mr_o), .MEM_W_EN_Out(b_mw_o),
    .ALU_Result_Out(b_alu_o), .src2_out(b_s2_o), .Dest_Out(b_dst_o),
    .freeze(freeze), .flush(flush),
    .count(b_count), .stall_cnt(b_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    wb = 1'b0; mr = 1'b0; mw = 1'b0;
    alu = '0; s2 = '0; dst = '0;
    freeze = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu", 64'(alu_o), 64'd0);
    chk("rst_src2", 64'(s2_o), 64'd0);
    chk("rst_dest", 64'(dst_o), 64'd0);
    chk("rst_ctrl", 64'({wb_o, mr_o, mw_o}), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    // streaming
    in_valid = 1'b1; out_ready = 1'b1; wb = 1'b1; mr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu = DW'(i); s2 = DW'(i * 16); dst = RW'(i + 2);
      tick();
      chk("str_alu", 64'(alu_o), 64'(i));
      chk("str_src2", 64'(s2_o), 64'(i * 16));
      chk("str_dest", 64'(dst_o), 64'(i + 2));
      chk("str_count", 64'(count), 64'd1);
      chk("str_valid", 64'(out_valid), 64'd1);
    end
    chk("str_ctrl", 64'({wb_o, mr_o, mw_o}), 64'b110);
    in_valid = 1'b0;
    tick();
    chk("str_drain", 64'(count), 64'd0);
    chk("str_stall", 64'(stall), 64'd0);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    wb = 1'b1; mr = 1'b0; mw = 1'b1;
    alu = 32'hA;
    tick();
    chk("bp_cnt1", 64'(count), 64'd1);
    alu = 32'hB;
    tick();
    chk("bp_cnt2", 64'(count), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_a", 64'(alu_o), 64'hA);
    alu = 32'hC;
    tick();
    chk("bp_stall1", 64'(stall), 64'd1);
    chk("bp_hold", 64'(count), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", 64'(alu_o), 64'hB);
    chk("bp_stall2", 64'(stall), 64'd2);
    chk("bp_cnt_b", 64'(count), 64'd1);
    tick();
    chk("bp_head_c", 64'(alu_o), 64'hC);
    chk("bp_ctrl_c", 64'({wb_o, mr_o, mw_o}), 64'b101);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", 64'(count), 64'd0);
    chk("bp_nop", 64'({wb_o, mr_o, mw_o}), 64'd0);

    // freeze
    out_ready = 1'b0; in_valid = 1'b1;
    alu = 32'hA;
    tick();
    alu = 32'hB;
    tick();
    in_valid = 1'b0; freeze = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_valid", 64'(out_valid), 64'd0);
      chk("frz_count", 64'(count), 64'd2);
      chk("frz_ctrl", 64'({wb_o, mr_o, mw_o}), 64'd0);
      chk("frz_in_ready", 64'(in_ready), 64'd0);
      chk("frz_data", 64'(alu_o), 64'hA);
    end
    freeze = 1'b0;
    #1;
    chk("frz_rel_valid", 64'(out_valid), 64'd1);
    chk("frz_rel_a", 64'(alu_o), 64'hA);
    tick();
    chk("frz_then_b", 64'(alu_o), 64'hB);
    chk("frz_cnt_b", 64'(count), 64'd1);
    tick();
    chk("frz_drain", 64'(count), 64'd0);

    // flush with simultaneous offer
    out_ready = 1'b0; in_valid = 1'b1;
    alu = 32'hA;
    tick();
    alu = 32'hB;
    tick();
    chk("fl_full", 64'(count), 64'd2);
    flush = 1'b1; alu = 32'hD;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_data_hold", 64'(alu_o), 64'hA);
    out_ready = 1'b1;
    tick();
    chk("fl_lost", 64'(count), 64'd0);

    // reset mid-run from FULL
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; mr = 1'b1;
    alu = 32'h11; s2 = 32'h22; dst = 4'h5;
    tick();
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("rm_stall5", 64'(stall), 64'd5);
    chk("rm_full", 64'(count), 64'd2);
    chk("sat_stall", 64'(b_stall), 64'd3);
    tick();
    chk("sat_hold", 64'(b_stall), 64'd3);
    chk("sat_main6", 64'(stall), 64'd6);
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rm_count", 64'(count), 64'd0);
    chk("rm_stall", 64'(stall), 64'd0);
    chk("rm_valid", 64'(out_valid), 64'd0);
    chk("rm_in_ready", 64'(in_ready), 64'd1);
    chk("rm_data", 64'({alu_o, s2_o}), 64'd0);
    chk("rm_dest", 64'(dst_o), 64'd0);
    chk("rm_ctrl", 64'({wb_o, mr_o, mw_o}), 64'd0);
    chk("rm_b_stall", 64'(b_stall), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
